// File: rtl/ntt_cmd_pkg.sv
// ntt_cmd_pkg: host opcodes, execute-kind encodings, command FSM states and
// the opcode decoder shared by the command receiver.
package ntt_cmd_pkg;

    // Word counter width: covers the largest data load, (2 << 15) - 1 words.
    localparam int CNT_W          = 17;
    // Default per-PE data address width (project-wide BRAM depth).
    localparam int BRAM_DEPTH_DEF = 8;

    localparam logic [4:0] OP_LD_PARAM = 5'b00001;
    localparam logic [4:0] OP_LD_TW    = 5'b00010;
    localparam logic [4:0] OP_LD_DATA  = 5'b00011;
    localparam logic [4:0] OP_NTT0     = 5'b00100;
    localparam logic [4:0] OP_NTT1     = 5'b01010;
    localparam logic [4:0] OP_PWM      = 5'b01100;
    localparam logic [4:0] OP_INTT     = 5'b00111;
    localparam logic [4:0] OP_READOUT  = 5'b01000;

    typedef enum logic [2:0] {
        KIND_NTT0    = 3'd0,
        KIND_NTT1    = 3'd1,
        KIND_PWM     = 3'd2,
        KIND_INTT    = 3'd3,
        KIND_READOUT = 3'd4
    } cmd_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_PARAM = 2'd1,
        ST_LD_TW    = 2'd2,
        ST_LD_DATA  = 2'd3
    } state_t;

    typedef struct packed {
        logic      is_load;
        logic      is_exec;
        state_t    load_state;
        cmd_kind_t kind;
    } op_dec_t;

    // Unrecognised opcodes decode to neither load nor execute.
    function automatic op_dec_t decode_op(input logic [4:0] op);
        op_dec_t d;
        d.is_load    = 1'b0;
        d.is_exec    = 1'b0;
        d.load_state = ST_IDLE;
        d.kind       = KIND_NTT0;
        case (op)
            OP_LD_PARAM: begin d.is_load = 1'b1; d.load_state = ST_LD_PARAM; end
            OP_LD_TW:    begin d.is_load = 1'b1; d.load_state = ST_LD_TW;    end
            OP_LD_DATA:  begin d.is_load = 1'b1; d.load_state = ST_LD_DATA;  end
            OP_NTT0:     begin d.is_exec = 1'b1; d.kind = KIND_NTT0;         end
            OP_NTT1:     begin d.is_exec = 1'b1; d.kind = KIND_NTT1;         end
            OP_PWM:      begin d.is_exec = 1'b1; d.kind = KIND_PWM;          end
            OP_INTT:     begin d.is_exec = 1'b1; d.kind = KIND_INTT;         end
            OP_READOUT:  begin d.is_exec = 1'b1; d.kind = KIND_READOUT;      end
            default:     ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ntt_cmd_rx_if.sv
// ntt_cmd_rx_if: host command bus plus parameter, twiddle, data and command
// outputs of the NTT command receiver. slave = receiver, master = host side.
interface ntt_cmd_rx_if #(
    parameter int DATA_W     = 32,
    parameter int PE_DEPTH   = 4,
    parameter int TW_AW      = 10,
    parameter int BRAM_DEPTH = 8
);
    logic [4:0]            OP_CODE;
    logic                  din_valid;
    logic [DATA_W-1:0]     din0;
    logic [3:0]            ring_depth;
    logic                  core_busy;

    logic [3:0]            pset;
    logic [DATA_W-1:0]     q;
    logic [DATA_W-1:0]     n_inv;
    logic                  param_valid;
    logic                  tw_we;
    logic [TW_AW-1:0]      tw_addr;
    logic [DATA_W-1:0]     tw_data;
    logic                  dat_we;
    logic [PE_DEPTH-1:0]   dat_pe;
    logic [BRAM_DEPTH-1:0] dat_addr;
    logic [DATA_W-1:0]     dat_data;
    logic                  cmd_start;
    logic [2:0]            cmd_kind;
    logic                  err;

    modport master (
        output OP_CODE, din_valid, din0, ring_depth, core_busy,
        input  pset, q, n_inv, param_valid, tw_we, tw_addr, tw_data,
               dat_we, dat_pe, dat_addr, dat_data, cmd_start, cmd_kind, err
    );

    modport slave (
        input  OP_CODE, din_valid, din0, ring_depth, core_busy,
        output pset, q, n_inv, param_valid, tw_we, tw_addr, tw_data,
               dat_we, dat_pe, dat_addr, dat_data, cmd_start, cmd_kind, err
    );
endinterface

// File: rtl/ntt_cmd_addrgen.sv
// ntt_cmd_addrgen: per-load word counter k. Maps k to a linear twiddle address
// (wrapping at 2^TW_AW) and to {pe, addr} for data loads, where the low
// PE_DEPTH bits pick the PE and the remaining bits form the BRAM address.
module ntt_cmd_addrgen
    import ntt_cmd_pkg::*;
#(
    parameter int PE_DEPTH   = 4,
    parameter int TW_AW      = 10,
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  tw_mode,
    input  logic [3:0]            ring_depth,
    output logic [CNT_W-1:0]      k,
    output logic [TW_AW-1:0]      tw_addr,
    output logic [PE_DEPTH-1:0]   pe,
    output logic [BRAM_DEPTH-1:0] addr,
    output logic                  data_last
);
    logic [CNT_W-1:0] k_reg;
    logic [CNT_W-1:0] k_next;
    logic [CNT_W-1:0] last_k;
    logic             tw_wrap;

    assign last_k  = (CNT_W'(2) << ring_depth) - CNT_W'(1);
    assign tw_wrap = &k_reg[TW_AW-1:0];

    // Next count: clear on a new load, step per accepted word, twiddles wrap.
    always_comb begin
        k_next = k_reg;
        if (clr) begin
            k_next = '0;
        end else if (inc) begin
            if (tw_mode && tw_wrap) begin
                k_next = '0;
            end else begin
                k_next = k_reg + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg <= '0;
        end else begin
            k_reg <= k_next;
        end
    end

    assign k         = k_reg;
    assign tw_addr   = k_reg[TW_AW-1:0];
    assign pe        = k_reg[PE_DEPTH-1:0];
    // k never exceeds (2 << ring_depth) - 1, so the upper bits are already
    // {k[ring_depth], k[ring_depth-1:PE_DEPTH]} and zero above that.
    assign addr      = BRAM_DEPTH'(k_reg >> PE_DEPTH);
    assign data_last = (k_reg == last_k);

endmodule

// File: rtl/ntt_cmd_rx.sv
// ntt_cmd_rx: host command receiver for the NTT core. Decodes opcodes, loads
// parameters / twiddles / polynomial data and issues execute pulses.
// Optional macro NTT_CMD_ERR_EN enables the sticky err flag; without it err
// is tied low and the detection logic is not built.
module ntt_cmd_rx
    import ntt_cmd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PE_DEPTH   = 4,
    parameter int TW_AW      = 10,
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF
) (
    input logic         clk,
    input logic         reset,
    ntt_cmd_rx_if.slave bus
);
    op_dec_t               dec;
    logic                  exec_ok;
    logic                  op_taken;
    logic                  word;
    logic                  take_param;
    logic                  take_tw;
    logic                  take_data;
    state_t                state_reg;
    state_t                state_next;

    logic [CNT_W-1:0]      ag_k;
    logic [TW_AW-1:0]      ag_tw_addr;
    logic [PE_DEPTH-1:0]   ag_pe;
    logic [BRAM_DEPTH-1:0] ag_addr;
    logic                  ag_data_last;

    logic                  tw_we_next;
    logic [TW_AW-1:0]      tw_addr_next;
    logic [DATA_W-1:0]     tw_data_next;
    logic                  dat_we_next;
    logic [PE_DEPTH-1:0]   dat_pe_next;
    logic [BRAM_DEPTH-1:0] dat_addr_next;
    logic [DATA_W-1:0]     dat_data_next;
    logic                  cmd_start_next;
    cmd_kind_t             cmd_kind_next;
    logic [3:0]            pset_next;
    logic [DATA_W-1:0]     q_next;
    logic [DATA_W-1:0]     n_inv_next;
    logic                  param_valid_next;

    assign dec      = decode_op(bus.OP_CODE);
    assign exec_ok  = dec.is_exec & ~bus.core_busy;
    // A recognised opcode owns its cycle; a word presented alongside it is dropped.
    assign op_taken = dec.is_load | dec.is_exec;
    assign word     = bus.din_valid & ~op_taken;

    assign take_param = word && (state_reg == ST_LD_PARAM);
    assign take_tw    = word && (state_reg == ST_LD_TW);
    assign take_data  = word && (state_reg == ST_LD_DATA);

    ntt_cmd_addrgen #(
        .PE_DEPTH   (PE_DEPTH),
        .TW_AW      (TW_AW),
        .BRAM_DEPTH (BRAM_DEPTH)
    ) u_addrgen (
        .clk        (clk),
        .reset      (reset),
        .clr        (dec.is_load),
        .inc        (take_param | take_tw | take_data),
        .tw_mode    (state_reg == ST_LD_TW),
        .ring_depth (bus.ring_depth),
        .k          (ag_k),
        .tw_addr    (ag_tw_addr),
        .pe         (ag_pe),
        .addr       (ag_addr),
        .data_last  (ag_data_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: loads preempt anything, accepted executes abort, loads end on their last word.
    always_comb begin
        state_next = state_reg;
        if (dec.is_load) begin
            state_next = dec.load_state;
        end else if (exec_ok) begin
            state_next = ST_IDLE;
        end else if (take_param && (ag_k == CNT_W'(2))) begin
            state_next = ST_IDLE;
        end else if (take_data && ag_data_last) begin
            state_next = ST_IDLE;
        end
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        tw_we_next       = take_tw;
        tw_addr_next     = ag_tw_addr;
        tw_data_next     = bus.din0;
        dat_we_next      = take_data;
        dat_pe_next      = ag_pe;
        dat_addr_next    = ag_addr;
        dat_data_next    = bus.din0;
        cmd_start_next   = exec_ok;
        cmd_kind_next    = exec_ok ? dec.kind : KIND_NTT0;
        pset_next        = bus.pset;
        q_next           = bus.q;
        n_inv_next       = bus.n_inv;
        param_valid_next = bus.param_valid;
        if (dec.load_state == ST_LD_PARAM && dec.is_load) begin
            param_valid_next = 1'b0;
        end
        if (take_param) begin
            case (ag_k[1:0])
                2'd0:    pset_next  = bus.din0[3:0];
                2'd1:    q_next     = bus.din0;
                default: n_inv_next = bus.din0;
            endcase
            if (ag_k == CNT_W'(2)) begin
                param_valid_next = 1'b1;
            end
        end
    end

    // Output registers: one cycle from input sample to strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tw_we       <= 1'b0;
            bus.tw_addr     <= '0;
            bus.tw_data     <= '0;
            bus.dat_we      <= 1'b0;
            bus.dat_pe      <= '0;
            bus.dat_addr    <= '0;
            bus.dat_data    <= '0;
            bus.cmd_start   <= 1'b0;
            bus.cmd_kind    <= '0;
            bus.pset        <= '0;
            bus.q           <= '0;
            bus.n_inv       <= '0;
            bus.param_valid <= 1'b0;
        end else begin
            bus.tw_we       <= tw_we_next;
            bus.tw_addr     <= tw_addr_next;
            bus.tw_data     <= tw_data_next;
            bus.dat_we      <= dat_we_next;
            bus.dat_pe      <= dat_pe_next;
            bus.dat_addr    <= dat_addr_next;
            bus.dat_data    <= dat_data_next;
            bus.cmd_start   <= cmd_start_next;
            bus.cmd_kind    <= cmd_kind_next;
            bus.pset        <= pset_next;
            bus.q           <= q_next;
            bus.n_inv       <= n_inv_next;
            bus.param_valid <= param_valid_next;
        end
    end

`ifdef NTT_CMD_ERR_EN
    logic exec_drop;
    logic err_next;
    logic readout_reg;
    logic readout_next;

    assign exec_drop = dec.is_exec & bus.core_busy;

    // Error events; after an accepted READOUT, IDLE words are its handshake.
    always_comb begin
        readout_next = readout_reg;
        if (dec.is_load) begin
            readout_next = 1'b0;
        end else if (exec_ok) begin
            readout_next = (dec.kind == KIND_READOUT);
        end
        err_next = bus.err
                 | exec_drop
                 | (word && (state_reg == ST_IDLE) && !readout_reg)
                 | (take_tw && (&ag_tw_addr));
    end

    // Sticky error flag and READOUT window, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err     <= 1'b0;
            readout_reg <= 1'b0;
        end else begin
            bus.err     <= err_next;
            readout_reg <= readout_next;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/ntt_cmd_rx.md
NTT_CMD_RX -- requirements
Module: ntt_cmd_rx

Interface
REQ-001 Parameters SHALL be: DATA_W 32, data word width; PE_DEPTH 4, log2 PE count (16 PEs); TW_AW 10, twiddle address width; BRAM_DEPTH from `defines.v`, per-PE data address width.
REQ-002 Ports SHALL be:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- OP_CODE, in, 5: host command, valid for one cycle.
- din_valid, in, 1: din0 carries a word this cycle.
- din0, in, 32: host data word.
- ring_depth, in, 4: log2 ring size (8 for 256).
- core_busy, in, 1: NTT core executing.
- pset, out, 4: parameter-set nibble.
- q, out, 32: modulus.
- n_inv, out, 32: inverse of n.
- param_valid, out, 1: all three parameters are loaded.
- tw_we, out, 1: twiddle write strobe.
- tw_addr, out, TW_AW: twiddle write address.
- tw_data, out, 32: twiddle write data.
- dat_we, out, 1: data BRAM write strobe.
- dat_pe, out, PE_DEPTH: target PE.
- dat_addr, out, BRAM_DEPTH: data write address.
- dat_data, out, 32: data write value.
- cmd_start, out, 1: one-cycle execute pulse.
- cmd_kind, out, 3: execute type, held with cmd_start.
- err, out, 1: sticky protocol error.

Function
REQ-003 Opcodes SHALL decode as follows; all other values are ignored:
- 00001: LD_PARAM.
- 00010: LD_TW.
- 00011: LD_DATA.
- 00100: NTT poly0 (kind 0).
- 01010: NTT poly1 (kind 1).
- 01100: PWM (kind 2).
- 00111: INTT (kind 3).
- 01000: READOUT (kind 4).
REQ-004 The FSM SHALL have exactly the states IDLE, LD_PARAM, LD_TW and LD_DATA.
REQ-005 A load opcode sampled in any state SHALL clear that load's word counter and enter the matching load state next cycle; din_valid in the opcode cycle SHALL be ignored.
REQ-006 In LD_PARAM, valid words 0, 1 and 2 SHALL register into pset (din0[3:0]), q and n_inv respectively; after word 2 the FSM SHALL return to IDLE and param_valid SHALL set.
REQ-007 param_valid SHALL clear on entry to LD_PARAM.
REQ-008 In LD_TW, each valid word SHALL produce tw_we=1 one cycle later, with tw_addr equal to the running count starting at 0 and tw_data=din0; the state SHALL persist until the next nonzero opcode.
REQ-009 In LD_DATA, valid word k (0..(2<<ring_depth)-1) SHALL produce dat_we one cycle later with:
- dat_pe = k[PE_DEPTH-1:0];
- dat_addr = {k[ring_depth], k[ring_depth-1:PE_DEPTH]}, zero-extended;
- dat_data = din0.
REQ-010 After word (2<<ring_depth)-1 the FSM SHALL return to IDLE.
REQ-011 Invalid cycles (din_valid=0) SHALL generate no write strobe and SHALL NOT advance any counter.
REQ-012 An execute opcode while core_busy=0 SHALL pulse cmd_start for exactly one cycle, the cycle after the opcode, with cmd_kind per REQ-003.
REQ-013 An execute opcode received in a load state SHALL abort the load to IDLE and SHALL still issue cmd_start.
REQ-014 An execute opcode while core_busy=1 SHALL be dropped and SHALL raise err.
REQ-015 din_valid in IDLE SHALL be ignored and SHALL raise err; the READOUT handshake (kind 4) is the sole exception.
REQ-016 A twiddle count passing 2^TW_AW-1 SHALL wrap to 0 and SHALL raise err.
REQ-017 Write strobes and cmd_start SHALL be registered outputs with latency exactly 1 cycle from the input sample.

Reset
REQ-018 While reset=1, every output SHALL be 0, the FSM SHALL be IDLE and all counters SHALL be 0.
REQ-019 Reset asserted mid-load SHALL discard the load; no partial strobe SHALL follow release.
REQ-020 err SHALL clear only on reset.

Configuration
REQ-021 With NTT_CMD_ERR_EN defined, err detection SHALL be as specified.
REQ-022 Without NTT_CMD_ERR_EN, err SHALL be tied 0 and the error logic omitted; wrap, drop and ignore behaviour SHALL be unchanged.

Structure
REQ-023 Package ntt_cmd_pkg SHALL hold the opcode constants, the cmd_kind encodings and the FSM state encoding.
REQ-024 Sub-module ntt_cmd_addrgen SHALL be used: a word counter that maps k to pe/addr for LD_DATA and to the linear address for LD_TW.

Verification
REQ-025 OP_CODE=00001, then 3 valid words 0xD, 0xD01, 0xC81 -> pset=0xD, q=3329, n_inv=0xC81, param_valid=1 in the cycle after word 3.
REQ-026 OP_CODE=00010, then 624 words -> 624 tw_we pulses at addresses 0..623, each with matching data, all 1 cycle after din_valid.
REQ-027 ring_depth=8, OP_CODE=00011, 512 words -> word 17 lands at pe=1, addr=1; word 300 lands at pe=12, addr=0x12; FSM returns to IDLE after word 511.
REQ-028 OP_CODE=00100 with core_busy=0 -> one cmd_start pulse with kind 0; the same opcode repeated with core_busy=1 -> no pulse and err=1.
REQ-029 OP_CODE=00111 issued after data word 100 -> load aborts, cmd_start kind 3 is issued, and no further dat_we occurs.
REQ-030 Reset asserted during LD_TW at word 50 -> all outputs 0; the next LD_TW starts at tw_addr=0.
